// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, rx state codes
// and the baud divisor helper used by both rx and tx.
package uart_pkg;

  localparam int CLOCK_FREQUENCY_DEF = 27000000;
  localparam int BAUD_RATE_DEF       = 115200;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE      = 3'd0;
  localparam rx_state_t RX_START     = 3'd1;
  localparam rx_state_t RX_DATA      = 3'd2;
  localparam rx_state_t RX_STOP      = 3'd3;
  localparam rx_state_t RX_WAIT_IDLE = 3'd4;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw rx pin plus falling-edge detect.
// Flops reset high so a low line at reset release reads as a start.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic s1;
  logic prev;

  // Metastability chain and previous-value history, idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
      prev <= rx_s;
    end
  end

  assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-entry valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEF,
  parameter int BAUD_RATE       = BAUD_RATE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_DIVISOR =
    baud_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CW = $clog2(BAUD_DIVISOR);
  localparam int S  = BAUD_DIVISOR / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = S + 1;
`else
  localparam int DEC = S;
`endif

  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIVISOR - 1);
  localparam logic [CW-1:0] CNT_DEC = CW'(DEC);

  logic          rx_s;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  rx_state_t     state;
  logic [7:0]    sr;
  logic          dec;
  logic          bit_v;
  logic          deliver;
  logic          bad_stop;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

  assign dec = (cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_SM1 = CW'(S - 1);
  localparam logic [CW-1:0] CNT_S   = CW'(S);

  logic smp_a;
  logic smp_b;

  // Hold the two early votes; the third is live rx_s at the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      if (cnt == CNT_SM1) smp_a <= rx_s;
      if (cnt == CNT_S)   smp_b <= rx_s;
    end
  end

  assign bit_v = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
`else
  assign bit_v = rx_s;
`endif

  assign deliver  = (state == RX_STOP) && dec && bit_v;
  assign bad_stop = (state == RX_STOP) && dec && !bit_v;

  // Bit-cell timer: parked at zero outside a frame, wraps per cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (state == RX_IDLE || state == RX_WAIT_IDLE) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      bit_idx <= bit_idx + 4'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Frame sequencing and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      sr    <= 8'h00;
    end else begin
      unique case (state)
        RX_IDLE: begin
          if (fall) state <= RX_START;
        end
        RX_START: begin
          if (dec) state <= bit_v ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (dec) begin
            sr <= {bit_v, sr[7:1]};
            if (bit_idx == 4'd8) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (dec) state <= bit_v ? RX_IDLE : RX_WAIT_IDLE;
        end
        RX_WAIT_IDLE: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Holding register handshake and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= sr;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
